// File: rtl/forwarding_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : forwarding_scoreboard_pkg                                    |
// | Description : Shared types and constants for the forwarding scoreboard.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package forwarding_scoreboard_pkg;

    localparam int SB_REGW = 5;

    typedef logic [SB_REGW-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        logic     is_load;
        regbits_t rd;
    } sb_entry_t;

    // Select value meaning "take the operand from the register file".
    localparam int FWD_REGFILE = 0;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/forwarding_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : forwarding_scoreboard_if                                     |
// | Description : Issue-side inputs and forwarding outputs of the scoreboard.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface forwarding_scoreboard_if #(
    parameter int NSRC = 2,
    parameter int REGW = 5,
    parameter int SELW = 2,
    parameter int CNTW = 32
);
    logic                   advance;
    logic                   flush;
    logic                   issue_valid;
    logic                   issue_wen;
    logic                   issue_is_load;
    logic [REGW-1:0]        issue_rd;
    logic [NSRC*REGW-1:0]   src_rs;
    logic [NSRC-1:0]        src_used;
    logic                   stall;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic [CNTW-1:0]        fwd_cnt;
    logic [CNTW-1:0]        stall_cnt;

    modport master (
        output advance, flush, issue_valid, issue_wen, issue_is_load,
               issue_rd, src_rs, src_used,
        input  stall, fwd_sel, fwd_cnt, stall_cnt
    );

    modport slave (
        input  advance, flush, issue_valid, issue_wen, issue_is_load,
               issue_rd, src_rs, src_used,
        output stall, fwd_sel, fwd_cnt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/forwarding_scoreboard_fwd_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : forwarding_scoreboard_fwd_match                              |
// | Description : Priority matcher of one source operand against all entries.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module forwarding_scoreboard_fwd_match
    import forwarding_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int IDXW   = $clog2(STAGES)
) (
    input  logic                    i_issue_valid,
    input  logic                    i_used,
    input  regbits_t                i_src,
    input  sb_entry_t [STAGES-1:0]  i_entries,
    output logic                    o_hit,
    output logic [IDXW-1:0]         o_idx,
    output logic                    o_is_load
);

    // Scan oldest to youngest so the youngest producer overwrites the result.
    always_comb begin
        o_hit     = 1'b0;
        o_idx     = '0;
        o_is_load = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (i_issue_valid && i_used && i_entries[k].valid &&
                (i_entries[k].rd != '0) && (i_entries[k].rd == i_src)) begin
                o_hit     = 1'b1;
                o_idx     = IDXW'(k);
                o_is_load = i_entries[k].is_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : forwarding_scoreboard                                        |
// | Description : Tracks in-flight register writes over STAGES stages past EX, |
// |               emits registered per-operand forward selects and a          |
// |               combinational load-use stall. Optional statistics counters   |
// |               are built when FWD_STATS_EN is defined.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int NSRC     = 2,
    parameter int REGW     = SB_REGW,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    forwarding_scoreboard_if.slave   bus
);

    localparam int SELW = sel_width(STAGES);
    localparam int IDXW = $clog2(STAGES);

    sb_entry_t [STAGES-1:0]      r_entry;
    logic [NSRC-1:0][SELW-1:0]   r_fwd_sel;
    logic [NSRC-1:0][SELW-1:0]   w_next_sel;
    logic [NSRC-1:0]             w_hit;
    logic [NSRC-1:0]             w_is_load;
    logic [NSRC-1:0]             w_load_use;
    logic [IDXW-1:0]             w_idx [NSRC];
    logic                        w_stall;
    logic                        w_bubble;

    generate
        for (genvar j = 0; j < NSRC; j++) begin : g_src
            forwarding_scoreboard_fwd_match #(
                .STAGES (STAGES),
                .IDXW   (IDXW)
            ) u_match (
                .i_issue_valid (bus.issue_valid),
                .i_used        (bus.src_used[j]),
                .i_src         (bus.src_rs[j*REGW +: REGW]),
                .i_entries     (r_entry),
                .o_hit         (w_hit[j]),
                .o_idx         (w_idx[j]),
                .o_is_load     (w_is_load[j])
            );

            // Load data only becomes forwardable once it has reached entry LOAD_LAT.
            assign w_load_use[j] = w_hit[j] && w_is_load[j] && (int'(w_idx[j]) < LOAD_LAT);
            assign w_next_sel[j] = w_hit[j] ? (SELW'(w_idx[j]) + SELW'(1)) : SELW'(FWD_REGFILE);
        end
    endgenerate

    assign w_stall  = bus.issue_valid && (|w_load_use) && !bus.flush;
    assign w_bubble = w_stall || bus.flush;

    assign bus.stall   = w_stall;
    assign bus.fwd_sel = r_fwd_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry   <= '0;
            r_fwd_sel <= '0;
        end else if (bus.advance) begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                r_entry[i] <= r_entry[i-1];
            end
            r_entry[0] <= w_bubble ? sb_entry_t'('0)
                                   : {bus.issue_valid && bus.issue_wen, bus.issue_is_load, bus.issue_rd};
            r_fwd_sel  <= w_bubble ? '0 : w_next_sel;
        end
    end

`ifdef FWD_STATS_EN
    logic [CNTW-1:0] r_fwd_cnt;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] w_fwd_inc;
    logic [CNTW:0]   w_fwd_sum;

    always_comb begin
        w_fwd_inc = '0;
        if (!w_bubble) begin
            for (int j = 0; j < NSRC; j++) begin
                if (w_next_sel[j] != '0) begin
                    w_fwd_inc = w_fwd_inc + CNTW'(1);
                end
            end
        end
    end

    assign w_fwd_sum = {1'b0, r_fwd_cnt} + {1'b0, w_fwd_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (bus.advance) begin
            r_fwd_cnt <= w_fwd_sum[CNTW] ? '1 : w_fwd_sum[CNTW-1:0];
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
        end
    end

    assign bus.fwd_cnt   = r_fwd_cnt;
    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.fwd_cnt   = {CNTW{1'b0}};
    assign bus.stall_cnt = {CNTW{1'b0}};
`endif

endmodule
`default_nettype wire
